config_sequencer: RTL

Sequences configuration writes into the tile array. Accepts (address, data) words from a host/bitstream source over a valid/ready handshake, buffers them in a small FIFO, and drives the shared `config_addr`/`config_data` broadcast bus that every tile decodes against its `tile_id` and section code. Each word is held for a programmable number of cycles, followed by a programmable idle gap. A done pulse marks the end of a bitstream.

---
 rtl/config_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/config_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : config_sequencer
// Brief   : Buffers (addr, data) config words and broadcasts each one on the
//           tile config bus for HOLD_CYCLES, then idles the bus for GAP_CYCLES.
// Revision: 1.0 - initial release
// ============================================================================
module config_sequencer #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HOLD_CYCLES = 1,
    parameter int          GAP_CYCLES  = 1,
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_strobe,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count
);

    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cw  = (c_max > 1) ? $clog2(c_max) : 1;
    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_hold_init = c_cw'(HOLD_CYCLES - 1);
    localparam logic [c_cw-1:0] c_gap_init  = c_cw'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [64:0]     r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    state_t          r_state;
    logic [c_cw-1:0] r_cnt;
    logic            r_cur_last;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_word_end;
    logic        w_slot_free;
    logic [64:0] w_head;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign in_ready = !w_full;
    assign busy     = !w_empty || (r_state != S_IDLE);

    // A word's slot ends on the last hold cycle (no gap) or the last gap cycle.
    assign w_word_end  = ((r_state == S_HOLD) && (r_cnt == '0) && (GAP_CYCLES == 0))
                      || ((r_state == S_GAP)  && (r_cnt == '0));
    assign w_slot_free = (r_state == S_IDLE) || w_word_end;
    assign w_pop       = w_slot_free && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_addr, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cur_last    <= 1'b0;
            config_addr   <= IDLE_ADDR;
            config_data   <= '0;
            config_strobe <= 1'b0;
            done          <= 1'b0;
            word_count    <= '0;
        end else begin
            done <= w_word_end && r_cur_last;
            if (w_pop) begin
                r_state       <= S_HOLD;
                r_cnt         <= c_hold_init;
                r_cur_last    <= w_head[64];
                config_addr   <= w_head[63:32];
                config_data   <= w_head[31:0];
                config_strobe <= 1'b1;
                // The word after a last-flagged word opens a new bitstream.
                if (r_cur_last) begin
                    word_count <= 16'd1;
                end else if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end else if (w_slot_free) begin
                r_state       <= S_IDLE;
                config_addr   <= IDLE_ADDR;
                config_data   <= '0;
                config_strobe <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_state       <= S_GAP;
                r_cnt         <= c_gap_init;
                config_addr   <= IDLE_ADDR;
                config_data   <= '0;
                config_strobe <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
